// File: rtl/aes_inv_key_walk.sv
// aes_inv_key_walk: walks AES-128 round keys from round 10 down to round 0 by undoing the expansion.
// Optional round-key replay cache is compiled in by defining INV_KEY_REPLAY_EN.
module aes_inv_key_walk #(
    parameter int KEY_LEN    = 128,
    parameter int WORD_LEN   = 32,
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid,
    output logic               key_ready,
    output logic [KEY_LEN-1:0] round_key,
    output logic [3:0]         round_idx,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2
`ifdef INV_KEY_REPLAY_EN
        , REPLAY = 2'd3
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [KEY_LEN-1:0]  cur_key;
    logic [3:0]          cur_round;
    logic                done_q;
    logic                handshake;
    logic                emit_hs;
    logic                last_round;
    logic [WORD_LEN-1:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [WORD_LEN-1:0] sb_in;
    logic [WORD_LEN-1:0] sb_out;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] b;
        case (r)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w4 = cur_key[4*WORD_LEN-1 -: WORD_LEN];
    assign w5 = cur_key[3*WORD_LEN-1 -: WORD_LEN];
    assign w6 = cur_key[2*WORD_LEN-1 -: WORD_LEN];
    assign w7 = cur_key[WORD_LEN-1:0];
    assign w3 = w7 ^ w6;
    assign w2 = w6 ^ w5;
    assign w1 = w5 ^ w4;
    assign sb_in = {w3[WORD_LEN-9:0], w3[WORD_LEN-1 -: 8]};
    // sb_out was captured during the EMIT handshake; cur_key is unchanged in SUB
    assign w0 = w4 ^ sb_out ^ {rcon(cur_round), {(WORD_LEN-8){1'b0}}};

`ifdef INV_KEY_REPLAY_EN
    assign rk_valid = (state == EMIT) || (state == REPLAY);
`else
    assign rk_valid = (state == EMIT);
`endif
    assign handshake  = rk_valid && rk_ready;
    assign emit_hs    = (state == EMIT) && rk_ready;
    assign last_round = (cur_round == 4'd0);
    assign key_ready  = (state == IDLE) && !reset;
    assign round_key  = cur_key;
    assign round_idx  = cur_round;
    assign done       = done_q;

    SubBytes #(.DATA_LEN(WORD_LEN)) u_sub_bytes (
        .clk      (clk),
        .reset_n  (!reset),
        .valid_in (emit_hs),
        .data_in  (sb_in),
        .data_out (sb_out)
    );

`ifdef INV_KEY_REPLAY_EN
    logic [KEY_LEN-1:0] cache [0:NUM_ROUNDS];
    logic               cache_ok;
    logic               hit;

    assign hit = cache_ok && (key_in == cache[NUM_ROUNDS]);

    always_ff @(posedge clk) begin
        if (state == EMIT)
            cache[cur_round] <= cur_key;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cache_ok <= 1'b0;
        else if (state == IDLE && key_valid && !hit)
            cache_ok <= 1'b0;
        else if (handshake && last_round)
            cache_ok <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_valid) begin
`ifdef INV_KEY_REPLAY_EN
                    state_nxt = hit ? REPLAY : EMIT;
`else
                    state_nxt = EMIT;
`endif
                end
            end
            EMIT: begin
                if (rk_ready)
                    state_nxt = last_round ? IDLE : SUB;
            end
            SUB: state_nxt = EMIT;
`ifdef INV_KEY_REPLAY_EN
            REPLAY: begin
                if (rk_ready && last_round)
                    state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_key   <= '0;
            cur_round <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= handshake && last_round;
            if (state == IDLE && key_valid) begin
                cur_key   <= key_in;
                cur_round <= NUM_ROUNDS[3:0];
            end else if (state == SUB) begin
                cur_key   <= {w0, w1, w2, w3};
                cur_round <= cur_round - 4'd1;
            end
`ifdef INV_KEY_REPLAY_EN
            else if (state == REPLAY && rk_ready && !last_round) begin
                cur_key   <= cache[cur_round - 4'd1];
                cur_round <= cur_round - 4'd1;
            end
`endif
        end
    end

endmodule

// SubBytes: AES S-box applied to every byte of data_in, registered when valid_in is high.
// The S-box is derived arithmetically: GF(2^8) inverse followed by the affine transform.
module SubBytes #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_in,
    input  logic [DATA_LEN-1:0] data_in,
    output logic [DATA_LEN-1:0] data_out
);

    logic [DATA_LEN-1:0] sub_w;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        sub_w = '0;
        for (int unsigned i = 0; i < DATA_LEN / 8; i++)
            sub_w[8*i +: 8] = sbox(data_in[8*i +: 8]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            data_out <= '0;
        else if (valid_in)
            data_out <= sub_w;
    end

endmodule

// File: tb/tb_aes_inv_key_walk.sv
// Self-checking bench for aes_inv_key_walk: a key-schedule model plus a cycle-level walk model,
// compared against the DUT on every negative clock edge.
module tb_aes_inv_key_walk;

`ifdef INV_KEY_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A1_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A1_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         done;

    always #5 clk = ~clk;

    aes_inv_key_walk #(.KEY_LEN(128), .WORD_LEN(32), .NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .done      (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]   sbox [256];
    logic [7:0]   rcon_t [11];
    logic [127:0] exp_rk [11];

    // walk model state
    bit           m_busy = 0, m_valid = 0, m_gap = 0, m_done = 0, m_replay = 0, m_cache_ok = 0;
    int           m_round = 0;
    logic [127:0] m_key10 = '0, m_cache10 = '0;

    // observed event times
    int t_acc = 0, t_done = -1;
    int t_r [11];
    bit done_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box by walking generator 3 and its inverse together
    task automatic init_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        rcon_t[0] = 8'h00;
        rcon_t[1] = 8'h01;
        for (int i = 2; i <= 10; i++)
            rcon_t[i] = {rcon_t[i-1][6:0], 1'b0} ^ (rcon_t[i-1][7] ? 8'h1b : 8'h00);
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    task automatic build_sched(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
        for (int i = 39; i >= 0; i--) begin
            t = w[i+3];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_t[(i+4)/4], 24'h0};
            w[i] = w[i+4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] fwd10(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[j] = k0[127-32*j -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_t[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        return {w[40], w[41], w[42], w[43]};
    endfunction

    // walk model: advanced on each rising edge from the bench's own inputs
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_busy = 0; m_valid = 0; m_gap = 0; m_done = 0; m_round = 0; m_cache_ok = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (key_valid) begin
                    build_sched(key_in);
                    m_replay = REPLAY && m_cache_ok && (key_in == m_cache10);
                    if (!m_replay) m_cache_ok = 0;
                    m_key10 = key_in;
                    m_busy = 1; m_valid = 1; m_round = 10;
                end
            end else if (m_valid && rk_ready) begin
                if (m_round == 0) begin
                    m_busy = 0; m_valid = 0; m_done = 1;
                    m_cache_ok = 1; m_cache10 = m_key10;
                end else if (m_replay) begin
                    m_round = m_round - 1;
                end else begin
                    m_valid = 0; m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0; m_valid = 1; m_round = m_round - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("rk_valid", rk_valid, m_valid);
        chk("done", done, m_done);
        chk("key_ready", key_ready, !m_busy && !reset);
        if (m_valid) begin
            chk("round_idx", round_idx, m_round);
            chk("round_key", round_key, exp_rk[m_round]);
        end
        if (key_valid && !m_busy && !reset) begin
            t_acc = cyc;
            t_done = -1;
            done_seen = 0;
            for (int i = 0; i <= 10; i++) t_r[i] = -1;
        end
        if (rk_valid && round_idx <= 4'd10 && t_r[round_idx] < 0) t_r[round_idx] = cyc;
        if (done) begin
            done_seen = 1;
            t_done = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] k);
        key_in = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!done_seen && n < maxc) begin
            step();
            n++;
        end
        chk("done_seen", done_seen, 1'b1);
    endtask

    task automatic lat_checks(input int gap);
        chk("lat_r10", t_r[10] - t_acc, 1);
        chk("lat_r9", t_r[9] - t_acc, 1 + gap);
        chk("lat_r0", t_r[0] - t_acc, 1 + 10 * gap);
        chk("lat_done", t_done - t_acc, 2 + 10 * gap);
    endtask

    initial begin
        logic [127:0] k2;
        reset = 1'b1;
        key_valid = 1'b0;
        key_in = '0;
        rk_ready = 1'b1;
        init_tables();

        build_sched(A1_K10);
        chk("model_k9", exp_rk[9], A1_K9);
        chk("model_k1", exp_rk[1], A1_K1);
        chk("model_k0", exp_rk[0], A1_K0);
        chk("model_fwd", fwd10(exp_rk[0]), A1_K10);

        step();
        step();
        @(negedge clk);
        chk("rst_round_key", round_key, '0);
        chk("rst_round_idx", round_idx, 4'd0);
        step();
        reset = 1'b0;
        step();

        // FIPS-197 A.1, no backpressure
        start(A1_K10);
        wait_done(40);
        lat_checks(2);

        // random key with 5 cycles of backpressure while round 7 is shown
        k2 = {$urandom, $urandom, $urandom, $urandom};
        start(k2);
        repeat (6) step();
        rk_ready = 1'b0;
        repeat (5) step();
        rk_ready = 1'b1;
        wait_done(50);
        chk("bp_r6", t_r[6] - t_acc, 14);
        chk("bp_done", t_done - t_acc, 27);

        // all-zero key; busy pulse at round 5 then reset at round 4
        start('0);
        repeat (10) step();
        key_in = A1_K10;
        key_valid = 1'b1;
        @(negedge clk);
        chk("busy_ready", key_ready, 1'b0);
        chk("busy_idx", round_idx, 4'd5);
        step();
        key_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", rk_valid, 1'b0);
        chk("rst_mid_idx", round_idx, 4'd0);
        chk("rst_mid_ready", key_ready, 1'b1);
        repeat (6) step();
        chk("rst_mid_no_done", done_seen, 1'b0);

        // restart reproduces A.1
        start(A1_K10);
        wait_done(40);
        lat_checks(2);

        if (REPLAY) begin
            start(A1_K10);
            wait_done(40);
            lat_checks(1);
        end

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
